// File: rtl/sp_link_pkg.sv
// sp_link_pkg: shared TX state type and byte geometry for the CIA serial-port link partner.
package sp_link_pkg;
  typedef enum logic [1:0] {IDLE, LOW, HIGH} tx_state_e;
  localparam int NBITS = 8;
endpackage

// File: rtl/sp_link_rx.sv
// sp_link_rx: CNT rising-edge sampler that assembles MSB-first bytes, with idle timeout on partial bytes.
module sp_link_rx
  import sp_link_pkg::*;
#(
  parameter int RX_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       res_n,
  input  logic       phi2_p,
  input  logic       sp_in,
  input  logic       cnt_in,
  input  logic       suppress,
  output logic       rx_edge,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_busy
);
  localparam int IW = $clog2(RX_TIMEOUT + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(RX_TIMEOUT - 1);
  localparam logic [2:0] BIT_LAST = 3'(NBITS - 1);
  logic          r_cnt_prev;
  logic [6:0]    r_shift;
  logic [2:0]    r_cnt;
  logic [IW-1:0] r_idle;
  logic [7:0]    r_data;
  logic          r_valid;
  assign rx_edge  = phi2_p & cnt_in & ~r_cnt_prev & ~suppress;
  assign rx_busy  = r_cnt != 3'd0;
  assign rx_data  = r_data;
  assign rx_valid = r_valid;
  // cnt_prev resets high: CNT idles high, so release must not look like an edge
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_cnt_prev <= 1'b1;
      r_shift    <= '0;
      r_cnt      <= '0;
      r_idle     <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (phi2_p) begin
        r_cnt_prev <= cnt_in;
        if (rx_edge) begin
          r_shift <= {r_shift[5:0], sp_in};
          r_cnt   <= r_cnt + 3'd1;
          r_idle  <= '0;
          if (r_cnt == BIT_LAST) begin
            r_data  <= {r_shift, sp_in};
            r_valid <= 1'b1;
          end
        end else if (rx_busy) begin
          r_cnt  <= (r_idle == IDLE_LAST) ? 3'd0 : r_cnt;
          r_idle <= (r_idle == IDLE_LAST) ? '0 : r_idle + IW'(1);
        end
      end
    end
  end
endmodule

// File: rtl/sp_link.sv
// sp_link: far-end partner for the CIA SP/CNT lines; TX FSM and RX/TX arbitration around sp_link_rx.
module sp_link
  import sp_link_pkg::*;
#(
  parameter int HALF_PERIOD = 4,
  parameter int RX_TIMEOUT  = 64
) (
  input  logic       clk,
  input  logic       res_n,
  input  logic       phi2_p,
  input  logic       sp_in,
  input  logic       cnt_in,
  output logic       sp_out,
  output logic       cnt_out,
  output logic       drive,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_busy
);
  localparam int HPW = $clog2(HALF_PERIOD + 1);
  localparam logic [HPW-1:0] HP_LAST = HPW'(HALF_PERIOD - 1);
  localparam logic [2:0] BIT_LAST = 3'(NBITS - 1);
  tx_state_e      r_state, w_state;
  logic [2:0]     r_bit, w_bit;
  logic [HPW-1:0] r_hp, w_hp;
  logic [6:0]     r_data, w_data;
  logic           r_sp, w_sp, r_cnt, w_cnt, r_drive, w_drive, r_done, w_done;
  logic           w_rx_edge, w_accept, w_hp_end;
  sp_link_rx #(.RX_TIMEOUT(RX_TIMEOUT)) u_rx (
    .clk      (clk),
    .res_n    (res_n),
    .phi2_p   (phi2_p),
    .sp_in    (sp_in),
    .cnt_in   (cnt_in),
    .suppress (r_drive),
    .rx_edge  (w_rx_edge),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_busy  (rx_busy)
  );
  assign sp_out   = r_sp;
  assign cnt_out  = r_cnt;
  assign drive    = r_drive;
  assign tx_done  = r_done;
  assign tx_ready = (r_state == IDLE) & ~rx_busy;
  // an RX edge starting a byte on the same tick takes priority over a TX request
  assign w_accept = tx_valid & tx_ready & ~w_rx_edge;
  assign w_hp_end = r_hp == HP_LAST;
  always_comb begin
    w_state = r_state;
    w_bit   = r_bit;
    w_hp    = r_hp;
    w_data  = r_data;
    w_sp    = r_sp;
    w_cnt   = r_cnt;
    w_drive = r_drive;
    w_done  = 1'b0;
    if (phi2_p) begin
      case (r_state)
        IDLE: if (w_accept) begin
          w_state = LOW;
          w_bit   = '0;
          w_hp    = '0;
          w_data  = tx_data[6:0];
          w_sp    = tx_data[7];
          w_cnt   = 1'b0;
          w_drive = 1'b1;
        end
        LOW: begin
          w_hp = w_hp_end ? '0 : r_hp + HPW'(1);
          if (w_hp_end) begin
            w_state = HIGH;
            w_cnt   = 1'b1;
          end
        end
        HIGH: begin
          w_hp = w_hp_end ? '0 : r_hp + HPW'(1);
          if (w_hp_end && r_bit == BIT_LAST) begin
            w_state = IDLE;
            w_done  = 1'b1;
            w_sp    = 1'b1;
            w_drive = 1'b0;
          end else if (w_hp_end) begin
            w_state = LOW;
            w_bit   = r_bit + 3'd1;
            w_data  = {r_data[5:0], 1'b0};
            w_sp    = r_data[6];
            w_cnt   = 1'b0;
          end
        end
        default: w_state = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_state <= IDLE;
      r_bit   <= '0;
      r_hp    <= '0;
      r_data  <= '0;
      r_sp    <= 1'b1;
      r_cnt   <= 1'b1;
      r_drive <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_bit   <= w_bit;
      r_hp    <= w_hp;
      r_data  <= w_data;
      r_sp    <= w_sp;
      r_cnt   <= w_cnt;
      r_drive <= w_drive;
      r_done  <= w_done;
    end
  end
endmodule

// File: doc/sp_link.md
# sp_link

Byte-level partner for the CIA serial port lines (SP/CNT), acting as the far end of the link. It receives bytes the CIA shifts out in output mode and transmits bytes toward a CIA in input mode. It sits beside the CIA on the same `clk`/`phi2_p` timebase, for example as the drive-side fast-serial shifter, and exposes a simple valid/ready byte interface to its host logic.

## Interface
- `HALF_PERIOD`, 4: `phi2_p` ticks per CNT half-period when transmitting; must be ≥1.
- `RX_TIMEOUT`, 64: `phi2_p` ticks without a CNT rising edge before a partial RX byte is discarded.
- `clk` in 1: system clock; one clock domain only.
- `res_n` in 1: reset, asynchronous, active-low.
- `phi2_p` in 1: Phi 2 positive-edge enable; all line sampling and state advance happens only on ticks.
- `sp_in` in 1: serial data line from the CIA.
- `cnt_in` in 1: CNT line from the CIA.
- `sp_out` out 1: serial data driven toward the CIA.
- `cnt_out` out 1: CNT driven toward the CIA.
- `drive` out 1: high while TX owns the lines; for open-collector/mux glue.
- `tx_data` in 8: byte to send.
- `tx_valid` in 1: transmit request.
- `tx_ready` out 1: byte accepted on a tick with `tx_valid & tx_ready`.
- `tx_done` out 1: one-clk pulse when the last bit's high half-period ends.
- `rx_data` out 8: last received byte; holds until the next byte completes.
- `rx_valid` out 1: one-clk pulse when `rx_data` is updated.
- `rx_busy` out 1: RX has one or more bits of a byte in progress.

## Operation
- Bits are MSB first. The CIA changes SP on CNT falling and samples on CNT rising; this block does the same in both directions.
- RX, active only when TX is idle:
  - On each tick, register `cnt_in` into `cnt_prev`. A rising edge is `cnt_in & ~cnt_prev`.
  - On a rising edge: `shift <= {shift[6:0], sp_in}` and `rx_cnt++` (3-bit counter).
  - When the 8th edge arrives (`rx_cnt==7`): `rx_data <= {shift[6:0], sp_in}`, pulse `rx_valid`, set `rx_cnt` to 0.
  - `rx_busy = (rx_cnt != 0)`.
  - Idle counter resets on each edge. When it reaches `RX_TIMEOUT` with `rx_busy`: set `rx_cnt` to 0 and discard the partial byte, with no `rx_valid`.
- TX FSM states IDLE, LOW, HIGH. Counters: 3-bit `tx_bit`, half-period counter `hp` (width `$clog2(HALF_PERIOD+1)`).
  - `tx_ready = (state==IDLE) & ~rx_busy`.
  - IDLE→LOW on accept: latch `tx_data`, `tx_bit=0`, `cnt_out=0`, `sp_out=tx_data[7]`, `drive=1`.
  - LOW→HIGH after `HALF_PERIOD` ticks: `cnt_out=1`.
  - HIGH→LOW after `HALF_PERIOD` ticks if `tx_bit!=7`: `tx_bit++`, `cnt_out=0`, `sp_out` set to the next bit.
  - HIGH→IDLE after `HALF_PERIOD` ticks if `tx_bit==7`: pulse `tx_done`, `sp_out=1`, `drive=0`.
- While `drive=1`, RX edge detection is suppressed. `cnt_prev` keeps tracking so the block's own edges are not counted on return to IDLE.
- Simultaneous events:
  - `tx_valid` on the same tick as an RX edge that starts a byte: RX wins and `tx_ready` drops next clk.
  - `tx_valid` on the same tick as a completing 8th edge: not accepted that tick, accepted on the next tick.

## Timing
- Reset values: `sp_out=1`, `cnt_out=1`, `drive=0`, `tx_ready=1`, `tx_done=0`, `rx_data=8'h00`, `rx_valid=0`, `rx_busy=0`, state IDLE, all counters 0.
- Reset is asynchronous: outputs take reset values immediately, including mid-byte. No partial byte is reported after release.
- RX latency: `rx_valid` is asserted on the clk edge of the tick that samples the 8th CNT rising edge, for exactly 1 clk.
- TX: `cnt_out` falls on the accept tick. A byte lasts `16*HALF_PERIOD` ticks. `tx_done` coincides with the return to IDLE, and `tx_ready` returns the same clk if `~rx_busy`.
- SP is stable for the full HIGH half-period of every bit.
- All output changes happen only on `phi2_p` clk edges, except reset.

## Structure
- `sp_link_pkg`: TX state enum (IDLE/LOW/HIGH) and bit-count constant 8.
- Sub-module `sp_link_rx`: edge detect, shift register, timeout, and `rx_*`/`rx_busy` outputs, with a `suppress` input driven by `drive`.
- TX FSM and arbitration stay in the top level.

## Test plan
- Reset: hold `res_n=0` mid-TX → `cnt_out=1`, `sp_out=1`, `drive=0`, `tx_ready=1` without waiting for a clk edge.
- RX 0xA5: drive 8 CNT pulses with SP changing on falling edges → `rx_data=8'hA5`, a single 1-clk `rx_valid`, `rx_busy` 1 from the 1st edge to the 8th.
- TX 0x3C, `HALF_PERIOD=4`: expect 8 low/high pulses of 4 ticks each; SP at the rising edges reads 0,0,1,1,1,1,0,0; `tx_done` 64 ticks after accept.
- RX timeout: 3 edges, then a 64-tick pause, then 8 edges carrying 0x81 → exactly one `rx_valid` with `rx_data=8'h81`.
- Arbitration: assert `tx_valid` (0x55) after the 2nd RX edge → `tx_ready=0` until the RX byte completes; 0x55 is sent afterwards; RX reports no spurious byte from the block's own pulses.
- `HALF_PERIOD=1`: TX 0xFF → CNT toggles every tick, byte done in 16 ticks.
